// File: rtl/coproc_pkg.sv
// Shared coprocessor constants: mode encoding and layout of the cause vector.
package coproc_pkg;

    localparam int CAUSE_W       = 2;
    localparam int CAUSE_OVF_BIT = 0;
    localparam int CAUSE_USR_BIT = 1;

    localparam logic MODE_NORMAL    = 1'b0;
    localparam logic MODE_INTERRUPT = 1'b1;

    typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/mode_sync.sv
// N-stage flop synchronizer with synchronous active-high reset.
module mode_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[N-1];

endmodule

// File: rtl/mode_logic_ctrl.sv
// Normal/interrupt mode selector with registered mode, cause and entry pulse.
// Build option MODE_LOGIC_SYNC_EN inserts a SYNC_STAGES-deep synchronizer on userInput.
module mode_logic_ctrl
    import coproc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               overflow,
    input  logic               userInput,
    input  logic               interruptsEnabled,
    output logic               mode,
    output logic [CAUSE_W-1:0] cause,
    output logic               mode_entry
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end

    logic   u_eff;
    logic   req;
    logic   mode_q, mode_d;
    cause_t cause_q, cause_d;
    logic   mode_entry_q, mode_entry_d;

`ifdef MODE_LOGIC_SYNC_EN
    mode_sync #(
        .N(SYNC_STAGES)
    ) u_mode_sync (
        .clk   (clk),
        .reset (reset),
        .d     (userInput),
        .q     (u_eff)
    );
`else
    assign u_eff = userInput;
`endif

    // Level-driven: mode tracks the masked request every cycle, nothing is latched.
    always_comb begin
        req          = interruptsEnabled & (overflow | u_eff);
        mode_d       = MODE_NORMAL;
        cause_d      = '0;
        mode_entry_d = 1'b0;
        if (req) begin
            mode_d                 = MODE_INTERRUPT;
            cause_d[CAUSE_OVF_BIT] = overflow;
            cause_d[CAUSE_USR_BIT] = u_eff;
            mode_entry_d           = (mode_q == MODE_NORMAL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_NORMAL;
            cause_q      <= '0;
            mode_entry_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            cause_q      <= cause_d;
            mode_entry_q <= mode_entry_d;
        end
    end

    assign mode       = mode_q;
    assign cause      = cause_q;
    assign mode_entry = mode_entry_q;

endmodule

// File: tb/tb_mode_logic_ctrl.sv
// Directed self-checking bench for mode_logic_ctrl; outputs compared as {mode, cause, mode_entry}.
module tb_mode_logic_ctrl;

    logic       clk;
    logic       reset;
    logic       overflow;
    logic       user_input;
    logic       ints_en;
    logic       mode;
    logic [1:0] cause;
    logic       mode_entry;

    int n_checks;
    int n_pass;

    mode_logic_ctrl #(
        .SYNC_STAGES(2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .overflow          (overflow),
        .userInput         (user_input),
        .interruptsEnabled (ints_en),
        .mode              (mode),
        .cause             (cause),
        .mode_entry        (mode_entry)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got mode/cause/entry=%b want %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic m, input logic [1:0] c, input logic e);
        check(tag, {mode, cause, mode_entry}, {m, c, e});
    endtask

    task automatic drive(input logic ie, input logic ov, input logic ui);
        ints_en    = ie;
        overflow   = ov;
        user_input = ui;
    endtask

    // masked-source vectors: {overflow, userInput}
    logic [1:0] masked_vec [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        expect_out("reset_dominates", 1'b0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        expect_out("after_reset", 1'b0, 2'b00, 1'b0);

        // all sources masked while interruptsEnabled=0
        for (int v = 0; v < 4; v++) begin
            drive(1'b0, masked_vec[v][1], masked_vec[v][0]);
            for (int k = 0; k < 3; k++) begin
                tick();
                expect_out("masked", 1'b0, 2'b00, 1'b0);
            end
        end

        // enabled sources
        drive(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("en_idle", 1'b0, 2'b00, 1'b0);
        overflow = 1'b1;
        tick();
        expect_out("ovf_entry", 1'b1, 2'b01, 1'b1);
        tick();
        expect_out("ovf_hold", 1'b1, 2'b01, 1'b0);
        user_input = 1'b1;
`ifdef MODE_LOGIC_SYNC_EN
        tick();
        expect_out("usr_sync_lag1", 1'b1, 2'b01, 1'b0);
        tick();
        expect_out("usr_sync_lag2", 1'b1, 2'b01, 1'b0);
`endif
        tick();
        expect_out("both_high", 1'b1, 2'b11, 1'b0);
        overflow = 1'b0;
        tick();
        expect_out("usr_only", 1'b1, 2'b10, 1'b0);
        user_input = 1'b0;
`ifdef MODE_LOGIC_SYNC_EN
        tick();
        expect_out("usr_drop_lag1", 1'b1, 2'b10, 1'b0);
        tick();
        expect_out("usr_drop_lag2", 1'b1, 2'b10, 1'b0);
`endif
        tick();
        expect_out("all_dropped", 1'b0, 2'b00, 1'b0);

        // enable toggling with overflow held high
        drive(1'b0, 1'b1, 1'b0);
        tick();
        expect_out("tog_masked", 1'b0, 2'b00, 1'b0);
        ints_en = 1'b1;
        tick();
        expect_out("tog_rise1", 1'b1, 2'b01, 1'b1);
        tick();
        expect_out("tog_hold1", 1'b1, 2'b01, 1'b0);
        ints_en = 1'b0;
        tick();
        expect_out("tog_fall", 1'b0, 2'b00, 1'b0);
        ints_en = 1'b1;
        tick();
        expect_out("tog_rise2", 1'b1, 2'b01, 1'b1);
        tick();
        expect_out("tog_hold2", 1'b1, 2'b01, 1'b0);

        // reset mid-service, source stays high
        reset = 1'b1;
        tick();
        expect_out("mid_reset", 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post_reset_entry", 1'b1, 2'b01, 1'b1);
        tick();
        expect_out("post_reset_hold", 1'b1, 2'b01, 1'b0);

        // both sources high but masked
        drive(1'b0, 1'b1, 1'b1);
        tick();
        expect_out("both_masked", 1'b0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("idle_again", 1'b0, 2'b00, 1'b0);

`ifdef MODE_LOGIC_SYNC_EN
        // userInput latency is SYNC_STAGES+1 edges, overflow stays 1 edge
        drive(1'b1, 1'b0, 1'b1);
        tick();
        expect_out("sync_e1", 1'b0, 2'b00, 1'b0);
        user_input = 1'b0;
        tick();
        expect_out("sync_e2", 1'b0, 2'b00, 1'b0);
        tick();
        expect_out("sync_e3", 1'b1, 2'b10, 1'b1);
        tick();
        expect_out("sync_e4", 1'b0, 2'b00, 1'b0);
        overflow = 1'b1;
        tick();
        expect_out("sync_ovf_fast", 1'b1, 2'b01, 1'b1);
`else
        // direct userInput: one-edge latency, same as overflow
        drive(1'b1, 1'b0, 1'b1);
        tick();
        expect_out("usr_direct", 1'b1, 2'b10, 1'b1);
        user_input = 1'b0;
        tick();
        expect_out("usr_direct_drop", 1'b0, 2'b00, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
